alu: RTL and testbench
======================

Name: alu

Overview:
- RV32-style R-type integer ALU for the simply5 core's execute stage.
- Decodes opcode/func3/func7 and produces a combinational result plus an error flag for unsupported encodings.
- Also provides a registered copy of result/error, clocked by the core clock, for pipeline capture.

Parameters:
- XLEN, 32, data width of operands and result.
- SHAMT_W, 5, shift-amount width; must equal $clog2(XLEN).

Ports:
- clk_i  input  1  core clock, rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- data1_i  input  XLEN  operand A (rs1).
- data2_i  input  XLEN  operand B (rs2).
- opcode_i  input  7  instruction opcode.
- func3_i  input  3  instruction funct3.
- func7_i  input  7  instruction funct7.
- result_o  output  XLEN  combinational result.
- error_o  output  1  combinational illegal-encoding flag.
- result_q_o  output  XLEN  result_o registered on clk_i.
- error_q_o  output  1  error_o registered on clk_i.

Behaviour:
- result_o/error_o are purely combinational: zero latency, and they settle within the same delta/time step as input changes.
- Only opcode 7'b0110011 is legal. Any other opcode: error_o=1, result_o=0.
- Decode (func3, func7), using the team's encoding:
  - 000 / 0100000: ADD, A+B.
  - 000 / 0000000: SUB, A-B.
  - 100 / 0000000: XOR, A^B.
  - 110 / 0000000: OR, A|B.
  - 111 / 0000000: AND, A&B.
  - 001 / 0000000: SLL, A << B[SHAMT_W-1:0].
  - 101 / 0000000: SRL, logical A >> B[SHAMT_W-1:0].
- Upper bits of B beyond SHAMT_W are ignored for shifts.
- Add/sub wrap modulo 2^XLEN; carry and overflow are discarded, with no flag.
- Any other func3/func7 combination: error_o=1, result_o=0. This covers func3 010/011 and func7 0100000 with func3 101 unless the optional feature is enabled.
- error_o=0 for every legal encoding.
- Registered outputs:
  - On rst_i=1 (asynchronous, regardless of clock), result_q_o=0 and error_q_o=0.
  - Otherwise, on each rising clk_i, result_q_o<=result_o and error_q_o<=error_o.
  - Reset asserted mid-stream clears both immediately. The first edge after deassertion captures the current combinational values.
- X/unknown inputs need no special handling.

Optional Feature:
- Macro: ALU_SIGNED_OPS_EN.
- Defined, the following become legal (error_o=0):
  - 010 / 0000000: SLT, signed A<B → 1 else 0.
  - 011 / 0000000: SLTU, unsigned compare.
  - 101 / 0100000: SRA, arithmetic A >>> B[SHAMT_W-1:0].
- Undefined, these three encodings give error_o=1, result_o=0.

Decomposition:
- Shared package alu_pkg holds:
  - Constant OPCODE_RTYPE = 7'b0110011.
  - func3 constants F3_ADDSUB, F3_SLL, F3_SLT, F3_SLTU, F3_XOR, F3_SRL, F3_OR, F3_AND.
  - func7 constants F7_ADD = 7'b0100000, F7_BASE = 7'b0000000.
  - An enum alu_op_e {ADD, SUB, XOR, OR, AND, SLL, SRL, SLT, SLTU, SRA, ILLEGAL}.
- One natural sub-module, alu_decode: maps opcode/func3/func7 to alu_op_e. The alu top holds the datapath and output registers.

Test Plan:
- ADD: func7=0100000, func3=000, A=32'hFFFF_FFFF, B=1 → result_o=0, error_o=0; 10 random pairs → (A+B) mod 2^32.
- SUB: func7=0000000, func3=000, A=5, B=7 → result_o=32'hFFFF_FFFE; XOR/OR/AND with A=32'hF0F0_00FF, B=32'h0FF0_0F0F → 32'hFF00_0FF0 / 32'hFFF0_0FFF / 32'h00F0_000F.
- Shifts: SLL A=32'h8000_0001, B=4 → 32'h0000_0010; SRL same operands → 32'h0800_0000; B=32'h0000_0021 (shamt=1) SLL A=1 → 2.
- Illegal: opcode=7'b0010011 → error_o=1, result_o=0; func3=000, func7=0000001 → error_o=1; func3=010 without ALU_SIGNED_OPS_EN → error_o=1.
- Registers: assert rst_i asynchronously between edges → result_q_o=0, error_q_o=0 immediately; release, apply ADD 3+4, one rising edge → result_q_o=7, error_q_o=0.
- With ALU_SIGNED_OPS_EN: SLT A=32'hFFFF_FFFF, B=1 → 1; SLTU same → 0; SRA A=32'h8000_0000, B=4 → 32'hF800_0000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings and operation enum for the R-type ALU.
// The decoder honours ALU_SIGNED_OPS_EN to enable SLT/SLTU/SRA.
package alu_pkg;

  localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SRL    = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  localparam logic [6:0] F7_ADD  = 7'b0100000;
  localparam logic [6:0] F7_BASE = 7'b0000000;

  typedef enum logic [3:0] {
    ADD,
    SUB,
    XOR,
    OR,
    AND,
    SLL,
    SRL,
    SLT,
    SLTU,
    SRA,
    ILLEGAL
  } alu_op_e;

endpackage

// File: rtl/alu_decode.sv
// Maps opcode/func3/func7 to an alu_op_e; anything unrecognised is ILLEGAL.
// Signed ops (SLT/SLTU/SRA) are decoded only when ALU_SIGNED_OPS_EN is defined.
module alu_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] func3_i,
  input  logic [6:0] func7_i,
  output alu_op_e    op_o
);

  logic f7_base;
  logic f7_add;

  assign f7_base = (func7_i == F7_BASE);
  assign f7_add  = (func7_i == F7_ADD);

  always_comb begin
    op_o = ILLEGAL;
    if (opcode_i == OPCODE_RTYPE) begin
      case (func3_i)
        // This core's encoding: F7_ADD selects ADD and F7_BASE selects SUB.
        F3_ADDSUB: begin
          if (f7_add) begin
            op_o = ADD;
          end else if (f7_base) begin
            op_o = SUB;
          end
        end
        F3_XOR: if (f7_base) op_o = XOR;
        F3_OR:  if (f7_base) op_o = OR;
        F3_AND: if (f7_base) op_o = AND;
        F3_SLL: if (f7_base) op_o = SLL;
        F3_SRL: begin
          if (f7_base) begin
            op_o = SRL;
          end
`ifdef ALU_SIGNED_OPS_EN
          else if (f7_add) begin
            op_o = SRA;
          end
`endif
        end
`ifdef ALU_SIGNED_OPS_EN
        F3_SLT:  if (f7_base) op_o = SLT;
        F3_SLTU: if (f7_base) op_o = SLTU;
`endif
        default: op_o = ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/alu.sv
// R-type integer ALU: combinational result/error plus a registered copy.
// Optional SLT/SLTU/SRA support is enabled by defining ALU_SIGNED_OPS_EN.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      func3_i,
  input  logic [6:0]      func7_i,
  output logic [XLEN-1:0] result_o,
  output logic            error_o,
  output logic [XLEN-1:0] result_q_o,
  output logic            error_q_o
);

  alu_op_e            op;
  logic [SHAMT_W-1:0] shamt;

  alu_decode u_decode (
    .opcode_i (opcode_i),
    .func3_i  (func3_i),
    .func7_i  (func7_i),
    .op_o     (op)
  );

  assign shamt = data2_i[SHAMT_W-1:0];

  always_comb begin
    result_o = '0;
    error_o  = 1'b0;
    case (op)
      ADD:  result_o = data1_i + data2_i;
      SUB:  result_o = data1_i - data2_i;
      XOR:  result_o = data1_i ^ data2_i;
      OR:   result_o = data1_i | data2_i;
      AND:  result_o = data1_i & data2_i;
      SLL:  result_o = data1_i << shamt;
      SRL:  result_o = data1_i >> shamt;
      SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
      SLTU: result_o = {{(XLEN-1){1'b0}}, (data1_i < data2_i)};
      SRA:  result_o = $unsigned($signed(data1_i) >>> shamt);
      default: begin
        result_o = '0;
        error_o  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_q_o <= '0;
      error_q_o  <= 1'b0;
    end else begin
      result_q_o <= result_o;
      error_q_o  <= error_o;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors plus randomized encodings
// compared against an arithmetic reference model.
module tb_alu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic [6:0]  opcode_i;
  logic [2:0]  func3_i;
  logic [6:0]  func7_i;
  logic [31:0] result_o;
  logic        error_o;
  logic [31:0] result_q_o;
  logic        error_q_o;

  int n_checks = 0;
  int n_fail   = 0;

  alu #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data1_i    (data1_i),
    .data2_i    (data2_i),
    .opcode_i   (opcode_i),
    .func3_i    (func3_i),
    .func7_i    (func7_i),
    .result_o   (result_o),
    .error_o    (error_o),
    .result_q_o (result_q_o),
    .error_q_o  (error_q_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: returns {error, result}.
  function automatic logic [32:0] model(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] a,
                                        input logic [31:0] b);
    int unsigned sh;
    logic [31:0] fill;
    sh = b % 32;
    if (opc != 7'b0110011) return {1'b1, 32'h0};
    if (f7 == 7'b0100000 && f3 == 3'd0) return {1'b0, a + b};
    if (f7 == 7'b0000000) begin
      case (f3)
        3'd0: return {1'b0, a - b};
        3'd4: return {1'b0, a ^ b};
        3'd6: return {1'b0, a | b};
        3'd7: return {1'b0, a & b};
        3'd1: return {1'b0, a << sh};
        3'd5: return {1'b0, a >> sh};
`ifdef ALU_SIGNED_OPS_EN
        3'd2: return {1'b0, (int'(a) < int'(b)) ? 32'd1 : 32'd0};
        3'd3: return {1'b0, (a < b) ? 32'd1 : 32'd0};
`endif
        default: return {1'b1, 32'h0};
      endcase
    end
`ifdef ALU_SIGNED_OPS_EN
    if (f7 == 7'b0100000 && f3 == 3'd5) begin
      fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
      return {1'b0, (a >> sh) | fill};
    end
`endif
    return {1'b1, 32'h0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
    opcode_i = opc;
    func3_i  = f3;
    func7_i  = f7;
    data1_i  = a;
    data2_i  = b;
    #1;
  endtask

  // Drive, then check both combinational outputs against constants.
  task automatic vec(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_res, input logic exp_err);
    drive(opc, f3, f7, a, b);
    check({tag, "_res"}, result_o, exp_res);
    check({tag, "_err"}, {31'h0, error_o}, {31'h0, exp_err});
  endtask

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] FB = 7'b0000000;
  localparam logic [6:0] FA = 7'b0100000;

  initial begin
    logic [32:0] exp;
    logic [31:0] a, b;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;

    rst_i = 1'b1;
    drive(R, 3'd0, FA, 32'd1, 32'd2);
    check("reset_res_q", result_q_o, 32'h0);
    check("reset_err_q", {31'h0, error_q_o}, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    vec("add_wrap", R, 3'd0, FA, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = $urandom;
      drive(R, 3'd0, FA, a, b);
      check("add_rand", result_o, a + b);
    end
    vec("sub", R, 3'd0, FB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
    vec("xor", R, 3'd4, FB, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 1'b0);
    vec("or",  R, 3'd6, FB, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1'b0);
    vec("and", R, 3'd7, FB, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0);
    vec("sll", R, 3'd1, FB, 32'h8000_0001, 32'd4, 32'h0000_0010, 1'b0);
    vec("srl", R, 3'd5, FB, 32'h8000_0001, 32'd4, 32'h0800_0000, 1'b0);
    vec("sll_hi_b", R, 3'd1, FB, 32'd1, 32'h0000_0021, 32'd2, 1'b0);
    vec("bad_opc", 7'b0010011, 3'd0, FA, 32'd3, 32'd4, 32'h0, 1'b1);
    vec("bad_f7", R, 3'd0, 7'b0000001, 32'd3, 32'd4, 32'h0, 1'b1);
`ifdef ALU_SIGNED_OPS_EN
    vec("slt",  R, 3'd2, FB, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    vec("sltu", R, 3'd3, FB, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    vec("sra",  R, 3'd5, FA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
`else
    vec("slt_off",  R, 3'd2, FB, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1);
    vec("sltu_off", R, 3'd3, FB, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1);
    vec("sra_off",  R, 3'd5, FA, 32'h8000_0000, 32'd4, 32'h0, 1'b1);
`endif

    // Load a non-zero value into the registers, then reset between edges.
    @(negedge clk_i);
    drive(R, 3'd0, FA, 32'd10, 32'd20);
    @(posedge clk_i);
    #1;
    check("pre_rst_q", result_q_o, 32'd30);
    @(negedge clk_i);
    drive(7'h0, 3'd0, FB, 32'd1, 32'd1);
    @(posedge clk_i);
    #1;
    check("err_q_set", {31'h0, error_q_o}, 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check("async_rst_res", result_q_o, 32'h0);
    check("async_rst_err", {31'h0, error_q_o}, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(R, 3'd0, FA, 32'd3, 32'd4);
    @(posedge clk_i);
    #1;
    check("post_rst_res", result_q_o, 32'd7);
    check("post_rst_err", {31'h0, error_q_o}, 32'h0);

    // Randomized encodings against the model, combinational and registered.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      opc = ($urandom_range(0, 7) == 0) ? 7'($urandom) : R;
      f3  = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       f7 = FB;
        1:       f7 = FA;
        2:       f7 = 7'($urandom);
        default: f7 = FA;
      endcase
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
      exp = model(opc, f3, f7, a, b);
      drive(opc, f3, f7, a, b);
      check("rand_res", result_o, exp[31:0]);
      check("rand_err", {31'h0, error_o}, {31'h0, exp[32]});
      @(posedge clk_i);
      #1;
      check("rand_res_q", result_q_o, exp[31:0]);
      check("rand_err_q", {31'h0, error_q_o}, {31'h0, exp[32]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
